sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: log2 of the number of 16-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 0..15: wait-state cycles inserted before each response.
REQ-003 Port Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port CE  input  1  chip enable, active-low.
REQ-006 Port OE  input  1  output (read) enable, active-low.
REQ-007 Port WE  input  1  write enable, active-low.
REQ-008 Port UB  input  1  upper byte lane [15:8] enable, active-low.
REQ-009 Port LB  input  1  lower byte lane [7:0] enable, active-low.
REQ-010 Port ADDR  input  20  word address; only ADDR[DEPTH_LOG2-1:0] is used, upper bits alias.
REQ-011 Port Data_in  input  16  write data from the initiator.
REQ-012 Port Data_out  output  16  read data to the initiator.
REQ-013 Port Ready  output  1  one-cycle pulse marking completion of an access.

Function
REQ-014 FSM states: IDLE, WAIT, RESP, HOLD, plus CLEAR when SRAM_RESP_CLEAR_EN is defined.
REQ-015 IDLE: access starts when CE=0 and (WE=0 or OE=0); ADDR, Data_in, UB, LB and the operation type are latched that cycle.
REQ-016 WE=0 with OE=0 simultaneously is a write; OE is ignored.
REQ-017 IDLE->WAIT when WAIT_CYCLES>0; IDLE->RESP directly when WAIT_CYCLES=0.
REQ-018 WAIT: a down-counter loaded with WAIT_CYCLES decrements each cycle; WAIT->RESP when it reaches 1; bus inputs are not re-sampled in WAIT.
REQ-019 Latency: Ready asserts exactly WAIT_CYCLES+1 cycles after the start cycle.
REQ-020 RESP, write: each byte lane with its enable low is written from latched data; lanes with enable high are unchanged; Ready=1 for one cycle.
REQ-021 RESP, read: Data_out is loaded with the stored word, disabled lanes forced to 8'h00; Ready=1 for one cycle.
REQ-022 UB=LB=1 completes normally with Ready; a write changes nothing and a read returns 16'h0000.
REQ-023 Data_out holds its last read value until the next read completes; writes do not alter it.
REQ-024 RESP->HOLD unconditionally; HOLD->IDLE once CE=1 or (OE=1 and WE=1); a held request is never served twice.
REQ-025 Ready is 0 in every state except RESP.
REQ-026 Write-then-read to the same address returns the written data; no read-during-write hazard is visible.

Reset
REQ-027 Reset=1 at a rising edge forces IDLE, Ready=0, Data_out=16'h0000 and the wait counter to 0, including mid-access.
REQ-028 An access interrupted by reset before RESP leaves storage unchanged.
REQ-029 Without SRAM_RESP_CLEAR_EN, storage contents are not affected by reset.

Configuration
REQ-030 Macro SRAM_RESP_CLEAR_EN defined: the cycle after Reset deasserts, the FSM enters CLEAR.
REQ-031 CLEAR writes 16'h0000 to one word per cycle, ascending from address 0, for 2^DEPTH_LOG2 cycles, then goes to IDLE.
REQ-032 During CLEAR, bus requests are ignored and Ready stays 0; a request still held when CLEAR ends is served from IDLE.
REQ-033 Macro undefined: no CLEAR state; IDLE follows reset immediately and power-up contents are unspecified.

Verification
REQ-034 WAIT_CYCLES=2: write ADDR=20'h00005, Data_in=16'hBEEF, UB=LB=0 -> Ready pulses 3 cycles after start. Then read the same address -> Data_out=16'hBEEF with Ready.
REQ-035 Write 16'h1234 to 20'h00010, then write 16'hAB00 with UB=0, LB=1 -> a full read returns 16'hAB34; a read with UB=1, LB=0 returns 16'h0034.
REQ-036 Hold CE=0, OE=0 for 10 cycles -> exactly one Ready pulse; a second Ready follows only after CE goes 1 and then back to 0.
REQ-037 Assert Reset during WAIT of a write to 20'h00020 -> Ready stays 0, Data_out=16'h0000, and a later read of 20'h00020 shows the prior contents.
REQ-038 DEPTH_LOG2=10: write 16'h5A5A to 20'h00400 -> a read of 20'h00000 returns 16'h5A5A (aliasing); WAIT_CYCLES=0 -> Ready 1 cycle after start.
REQ-039 With SRAM_RESP_CLEAR_EN: after reset, a read issued immediately gets no Ready for 1024 cycles, then returns 16'h0000.

Source files
------------

// File: rtl/sram_responder.sv
// Wait-state SRAM responder with byte lanes and one-shot Ready per held request.
// Optional macro SRAM_RESP_CLEAR_EN zero-fills the whole array after every reset.
module sram_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Ready
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RESP,
`ifdef SRAM_RESP_CLEAR_EN
        HOLD,
        CLEAR
`else
        HOLD
`endif
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [15:0]             data_q;
    logic                    ub_q;
    logic                    lb_q;
    logic                    wr_q;
    logic [15:0]             dout_q;
    logic                    ready_q;
`ifdef SRAM_RESP_CLEAR_EN
    logic                    clrPend_q;
    logic [DEPTH_LOG2-1:0]   clrAddr_q;
`endif

    logic [15:0]             mem [DEPTH];

    logic                    startReq;
    logic                    idleServe;
    logic                    fire;
    logic                    curWr;
    logic                    curUb;
    logic                    curLb;
    logic [DEPTH_LOG2-1:0]   curAddr;
    logic [15:0]             curData;
    logic [15:0]             readWord;
    logic [15:0]             readMasked;
    logic                    memWeHi_d;
    logic                    memWeLo_d;
    logic [DEPTH_LOG2-1:0]   memAddr_d;
    logic [15:0]             memWdata_d;
    logic                    unusedAddrBits;

    assign unusedAddrBits = ^ADDR[19:DEPTH_LOG2];

    assign startReq = ~CE & (~WE | ~OE);

`ifdef SRAM_RESP_CLEAR_EN
    assign idleServe = (state_q == IDLE) & ~clrPend_q;
`else
    assign idleServe = (state_q == IDLE);
`endif

    // With zero wait states the access completes straight from IDLE, so the live bus is used.
    assign curWr   = (state_q == IDLE) ? ~WE                    : wr_q;
    assign curUb   = (state_q == IDLE) ? UB                     : ub_q;
    assign curLb   = (state_q == IDLE) ? LB                     : lb_q;
    assign curAddr = (state_q == IDLE) ? ADDR[DEPTH_LOG2-1:0]   : addr_q;
    assign curData = (state_q == IDLE) ? Data_in                : data_q;

    assign fire = ~Reset & ((idleServe & startReq & (WAIT_CYCLES == 0)) |
                            ((state_q == WAIT) & (cnt_q == 4'd1)));

    assign readWord   = mem[curAddr];
    assign readMasked = {curUb ? 8'h00 : readWord[15:8], curLb ? 8'h00 : readWord[7:0]};

    always_comb begin
        memWeHi_d  = 1'b0;
        memWeLo_d  = 1'b0;
        memAddr_d  = curAddr;
        memWdata_d = curData;
        if (fire && curWr) begin
            memWeHi_d = ~curUb;
            memWeLo_d = ~curLb;
        end
`ifdef SRAM_RESP_CLEAR_EN
        if (!Reset && state_q == CLEAR) begin
            memWeHi_d  = 1'b1;
            memWeLo_d  = 1'b1;
            memAddr_d  = clrAddr_q;
            memWdata_d = 16'h0000;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (memWeHi_d) mem[memAddr_d][15:8] <= memWdata_d[15:8];
        if (memWeLo_d) mem[memAddr_d][7:0]  <= memWdata_d[7:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            dout_q  <= 16'h0000;
`ifdef SRAM_RESP_CLEAR_EN
            clrPend_q <= 1'b1;
            clrAddr_q <= '0;
`endif
        end else begin
            ready_q <= fire;
            if (fire && !curWr) dout_q <= readMasked;
            case (state_q)
                IDLE: begin
`ifdef SRAM_RESP_CLEAR_EN
                    if (clrPend_q) begin
                        state_q   <= CLEAR;
                        clrPend_q <= 1'b0;
                        clrAddr_q <= '0;
                    end else
`endif
                    if (startReq) begin
                        addr_q <= ADDR[DEPTH_LOG2-1:0];
                        data_q <= Data_in;
                        ub_q   <= UB;
                        lb_q   <= LB;
                        wr_q   <= ~WE;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
                RESP: state_q <= HOLD;
                // Stay here until the initiator drops the request so it is served only once.
                HOLD: if (CE || (OE && WE)) state_q <= IDLE;
`ifdef SRAM_RESP_CLEAR_EN
                CLEAR: begin
                    clrAddr_q <= clrAddr_q + 1'b1;
                    if (clrAddr_q == '1) state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Data_out = dout_q;
    assign Ready    = ready_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against an array-based memory model.
// Covers latency, byte lanes, aliasing, single service per held request and mid-access reset.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CE, OE, WE, UB, LB;
    logic [19:0] ADDR;
    logic [15:0] Data_in;
    logic [15:0] dOut, dOut0;
    logic        rdy, rdy0;
    logic        ce0Mask;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] model [1024];
    logic [15:0] lastRd;

    always #5 Clk = ~Clk;

    sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .ADDR(ADDR), .Data_in(Data_in), .Data_out(dOut), .Ready(rdy)
    );

    sram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .CE(CE | ce0Mask), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .ADDR(ADDR), .Data_in(Data_in), .Data_out(dOut0), .Ready(rdy0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete bus access held for 8 cycles, then released; model decides the expected result.
    task automatic applyStimulus(input bit wr, input logic [19:0] a, input logic [15:0] d,
                                 input bit ubN, input bit lbN);
        int lat = -1, lat0 = -1, pulses = 0, pulses0 = 0;
        logic [9:0]  idx;
        logic [15:0] expRd;
        @(negedge Clk);
        CE = 1'b0; WE = !wr; OE = wr ? 1'($urandom_range(0, 1)) : 1'b0;
        ADDR = a; Data_in = d; UB = ubN; LB = lbN;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                ADDR = 20'($urandom); Data_in = 16'($urandom);
                UB = 1'($urandom_range(0, 1)); LB = 1'($urandom_range(0, 1));
            end
            if (rdy)  begin pulses++;  if (lat < 0)  lat = k;  end
            if (rdy0) begin pulses0++; if (lat0 < 0) lat0 = k; end
        end
        idx = a[9:0];
        if (wr) begin
            if (!ubN) model[idx][15:8] = d[15:8];
            if (!lbN) model[idx][7:0]  = d[7:0];
        end else begin
            expRd  = model[idx];
            lastRd = {ubN ? 8'h00 : expRd[15:8], lbN ? 8'h00 : expRd[7:0]};
        end
        checkOutput("latency_w2", lat, 3);
        checkOutput("latency_w0", lat0, 1);
        checkOutput("pulses_w2", pulses, 1);
        checkOutput("pulses_w0", pulses0, 1);
        checkOutput("dout_w2", {16'h0, dOut}, {16'h0, lastRd});
        checkOutput("dout_w0", {16'h0, dOut0}, {16'h0, lastRd});
        CE = 1'b1; WE = 1'b1; OE = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
        ADDR = '0; Data_in = '0; ce0Mask = 1'b0; lastRd = 16'h0000;
        repeat (2) @(negedge Clk);
        checkOutput("reset_ready", {30'h0, rdy, rdy0}, 32'h0);
        checkOutput("reset_dout", {dOut, dOut0}, 32'h0);
        Reset = 1'b0;
        @(negedge Clk);

        // Fill the array so every later read has a defined expectation.
        for (int i = 0; i < 1024; i++) applyStimulus(1'b1, 20'(i), 16'($urandom), 1'b0, 1'b0);

        applyStimulus(1'b1, 20'h00005, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0);
        checkOutput("beef_read", {16'h0, dOut}, 32'h0000BEEF);

        applyStimulus(1'b1, 20'h00010, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 20'h00010, 16'hAB00, 1'b0, 1'b1);
        applyStimulus(1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0);
        checkOutput("lane_full", {16'h0, dOut}, 32'h0000AB34);
        applyStimulus(1'b0, 20'h00010, 16'h0000, 1'b1, 1'b0);
        checkOutput("lane_low", {16'h0, dOut}, 32'h00000034);
        applyStimulus(1'b0, 20'h00010, 16'h0000, 1'b1, 1'b1);
        checkOutput("lane_none", {16'h0, dOut}, 32'h00000000);
        applyStimulus(1'b1, 20'h00010, 16'hFFFF, 1'b1, 1'b1);
        applyStimulus(1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0);
        checkOutput("nolane_write", {16'h0, dOut}, 32'h0000AB34);

        applyStimulus(1'b1, 20'h00400, 16'h5A5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 20'h00000, 16'h0000, 1'b0, 1'b0);
        checkOutput("alias_read", {16'h0, dOut0}, 32'h00005A5A);

        // Reset during the wait states of a write must cancel it.
        ce0Mask = 1'b1;
        @(negedge Clk);
        CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = 1'b0; LB = 1'b0;
        ADDR = 20'h00020; Data_in = ~model[10'h020];
        @(negedge Clk);
        checkOutput("midwait_ready", {31'h0, rdy}, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midreset_ready", {31'h0, rdy}, 32'h0);
        checkOutput("midreset_dout", {16'h0, dOut}, 32'h0);
        CE = 1'b1; WE = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; ce0Mask = 1'b0; lastRd = 16'h0000;
        @(negedge Clk);
        checkOutput("postreset_ready", {31'h0, rdy}, 32'h0);
        applyStimulus(1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++)
            applyStimulus(1'($urandom_range(0, 1)), 20'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
